tug_referee: RTL
================

Name: tug_referee

Overview:
- Game-control stage for the tug-of-war design.
- Sits directly downstream of the per-player key debouncers, which supply single-cycle press pulses, and upstream of the score display drivers.
- Runs the match: start countdown, rope position, round-win detection, score accumulation and match-over lockout.
- Produces the 15-LED rope bar and the 2-bit per-side scores consumed by the seven-segment score drivers.

Parameters:
- TICK_CYCLES, 100000000: clk cycles per game tick (1 s at 100 MHz).
- CD_TICKS, 3: countdown length in ticks before play opens; range 1..3.
- HOLD_TICKS, 2: ticks the winning LED is held after a round before the next countdown.
- WIN_ROUNDS, 3: round wins needed to take the match; range 1..3.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a match from IDLE
- l_pulse  in  1  debounced left-player press, one cycle wide
- r_pulse  in  1  debounced right-player press, one cycle wide
- pos  out  4  rope position 1..15; centre = 8
- led  out  15  one-hot rope bar, bit (pos-1) set
- score_l  out  2  left rounds won
- score_r  out  2  right rounds won
- cd_digit  out  2  remaining countdown ticks; 0 outside COUNTDOWN
- playing  out  1  high in PLAY only
- match_over  out  1  high in MATCH_END
- winner  out  1  valid when match_over; 1 = left, 0 = right

Behaviour:
- Reset (async, rstn low):
  - state = IDLE, pos = 8, led = 15'h0080, scores = 0.
  - cd_digit = 0, playing = 0, match_over = 0, winner = 0, tick counter = 0.
  - Asserting rstn mid-match aborts the match immediately.
- Tick generator:
  - Counter 0..TICK_CYCLES-1, free-running only in COUNTDOWN and ROUND_END.
  - Cleared on every state entry.
  - tick = 1 for one cycle when the counter wraps.
- IDLE:
  - pos = 8.
  - On start: scores <= 0, go to COUNTDOWN, cd_digit <= CD_TICKS.
  - l_pulse and r_pulse are ignored.
- COUNTDOWN:
  - pos is forced to 8.
  - Each tick decrements cd_digit.
  - On the tick where cd_digit is 1: cd_digit <= 0, go to PLAY; playing is registered high on the next cycle.
  - Presses are ignored; see FALSE_START_EN.
- PLAY:
  - l_pulse alone: pos <= pos+1.
  - r_pulse alone: pos <= pos-1.
  - Both in the same cycle: no move.
  - Round win is detected on the registered pos:
    - pos == 15: score_l <= score_l+1.
    - pos == 1: score_r <= score_r+1.
    - Score update and state change happen in the cycle after pos reaches the end; presses in that cycle are ignored.
    - pos never leaves 1..15.
  - If the new score equals WIN_ROUNDS: winner <= side, go to MATCH_END.
  - Otherwise go to ROUND_END.
- ROUND_END:
  - pos is held at the end value; further presses are ignored.
  - After HOLD_TICKS ticks: pos <= 8, cd_digit <= CD_TICKS, go to COUNTDOWN.
- MATCH_END:
  - match_over = 1; pos, scores and winner are frozen.
  - start returns to COUNTDOWN with scores cleared, pos = 8, match_over = 0.
- Output timing:
  - led is decoded combinationally from registered pos.
  - All other outputs are registered.
- Edge cases:
  - start outside IDLE/MATCH_END: ignored.
  - A score already at WIN_ROUNDS cannot increment further, because MATCH_END is entered first.

Optional Feature:
- Macro: TUG_FALSE_START_EN.
- When defined, presses during COUNTDOWN are penalised:
  - Each l_pulse lowers a signed start offset by 1.
  - Each r_pulse raises it by 1.
  - Offset saturates at ±2; simultaneous presses cancel.
  - On entry to PLAY: pos <= 8 + offset, offset <= 0.
  - A false start therefore shifts the starting position away from the offending side.
- When undefined:
  - Countdown presses are ignored and PLAY always starts at pos 8.
  - No offset register is built.

Test Plan:
- Reset check (TICK_CYCLES=4 for all tests): reset, then start -> cd_digit 3,2,1 at 4-cycle spacing; playing=1 after 12 cycles; pos=8, led=15'h0080.
- Left round win: 7 l_pulses in PLAY -> pos 15, led=15'h4000; next cycle score_l=1 and state ROUND_END; after 8 cycles back in COUNTDOWN with pos=8.
- Simultaneous press: l_pulse and r_pulse in the same cycle at pos 8 -> pos stays 8. Boundary hold: l_pulse during ROUND_END -> pos stays 15, score unchanged.
- Match end: right wins 3 rounds -> score_r=3, match_over=1, winner=0; later presses change nothing; start -> scores 0, COUNTDOWN.
- Reset mid-match: rstn low during PLAY at pos 11 with score_l=2 -> immediately pos=8, scores=0, IDLE.
- With TUG_FALSE_START_EN: 3 l_pulses during countdown -> PLAY starts at pos 6 (saturated at -2). Without the macro, the same stimulus -> pos 8.

Source files
------------

// File: rtl/tug_referee.sv
// tug_referee: tug-of-war match control (countdown, rope position, round/match scoring)
// Ports: clk, rstn (async active-low); start, l_pulse, r_pulse (single-cycle pulses);
//        pos (rope 1..15, centre 8), led (one-hot bar, bit pos-1), score_l/score_r,
//        cd_digit (countdown ticks left), playing, match_over, winner (1 = left).
// Optional: define TUG_FALSE_START_EN to turn countdown presses into a start offset.
module tug_referee #(
  parameter int TICK_CYCLES = 100000000,
  parameter int CD_TICKS = 3,
  parameter int HOLD_TICKS = 2,
  parameter int WIN_ROUNDS = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        l_pulse,
  input  logic        r_pulse,
  output logic [3:0]  pos,
  output logic [14:0] led,
  output logic [1:0]  score_l,
  output logic [1:0]  score_r,
  output logic [1:0]  cd_digit,
  output logic        playing,
  output logic        match_over,
  output logic        winner
);
  localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, ROUND_END, MATCH_END} state_t;
  state_t state;
  logic [TW-1:0] cnt;
  logic [7:0] hold;
  logic tick;
  logic [1:0] inc_l, inc_r;
  logic [3:0] start_pos;
  assign tick = cnt == TW'(TICK_CYCLES - 1);
  assign led = 15'd1 << (pos - 4'd1);
  assign inc_l = score_l + 2'd1;
  assign inc_r = score_r + 2'd1;
`ifdef TUG_FALSE_START_EN
  logic signed [2:0] off;
  assign start_pos = 4'd8 + {off[2], off};
  // offset only lives during a countdown; it is consumed on the tick that opens play
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) off <= '0;
    else if (state != COUNTDOWN || (tick && cd_digit == 2'd1)) off <= '0;
    else if (l_pulse && !r_pulse && off != -3'sd2) off <= off - 3'sd1;
    else if (r_pulse && !l_pulse && off != 3'sd2) off <= off + 3'sd1;
`else
  assign start_pos = 4'd8;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      pos <= 4'd8;
      score_l <= '0;
      score_r <= '0;
      cd_digit <= '0;
      playing <= 1'b0;
      match_over <= 1'b0;
      winner <= 1'b0;
      cnt <= '0;
      hold <= '0;
    end else begin
      // every state change into a timed state happens on a tick or from an untimed state,
      // so clearing on tick/outside timed states also clears on entry
      cnt <= ((state == COUNTDOWN || state == ROUND_END) && !tick) ? cnt + TW'(1) : '0;
      unique case (state)
        IDLE: begin
          pos <= 4'd8;
          if (start) begin
            score_l <= '0;
            score_r <= '0;
            cd_digit <= 2'(CD_TICKS);
            state <= COUNTDOWN;
          end
        end
        COUNTDOWN: begin
          pos <= 4'd8;
          if (tick && cd_digit == 2'd1) begin
            cd_digit <= '0;
            pos <= start_pos;
            playing <= 1'b1;
            state <= PLAY;
          end else if (tick) cd_digit <= cd_digit - 2'd1;
        end
        PLAY: begin
          if (pos == 4'd15 || pos == 4'd1) begin
            playing <= 1'b0;
            hold <= '0;
            if (pos == 4'd15) score_l <= inc_l;
            else score_r <= inc_r;
            if ((pos == 4'd15 ? inc_l : inc_r) == 2'(WIN_ROUNDS)) begin
              winner <= pos == 4'd15;
              match_over <= 1'b1;
              state <= MATCH_END;
            end else state <= ROUND_END;
          end else if (l_pulse && !r_pulse) pos <= pos + 4'd1;
          else if (r_pulse && !l_pulse) pos <= pos - 4'd1;
        end
        ROUND_END: begin
          if (tick && hold == 8'(HOLD_TICKS - 1)) begin
            hold <= '0;
            pos <= 4'd8;
            cd_digit <= 2'(CD_TICKS);
            state <= COUNTDOWN;
          end else if (tick) hold <= hold + 8'd1;
        end
        MATCH_END: begin
          if (start) begin
            score_l <= '0;
            score_r <= '0;
            pos <= 4'd8;
            match_over <= 1'b0;
            cd_digit <= 2'(CD_TICKS);
            state <= COUNTDOWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
